l2_cache_ctrl: RTL

- Direct-mapped, write-back L2 cache.
- Acts as the responder to the coherence bus L2 request channel: accepts read and write-back requests, returns read data, and services misses and dirty evictions through a single-outstanding memory port.
- Sits between the coherence bus and main memory; processes one request at a time.

---
 rtl/l2_cache_ctrl_pkg.sv | 46 ++++
 rtl/l2_cache_ctrl_tag_data_array.sv | 27 ++
 rtl/l2_cache_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/l2_cache_ctrl_pkg.sv
// Shared types and widths for the direct-mapped write-back L2 controller.
// The optional statistics counters are enabled by defining L2_STATS_EN.
package l2_cache_ctrl_pkg;

  localparam int L2_TAG_BITS    = 2;
  localparam int L2_INDEX_BITS  = 4;
  localparam int CACHELINE_BITS = 1;
  localparam int L2_ADDR_W      = L2_TAG_BITS + L2_INDEX_BITS;
  localparam int L2_SETS        = 1 << L2_INDEX_BITS;

  typedef enum logic [1:0] {
    L2_I = 2'd0,
    L2_C = 2'd1,
    L2_D = 2'd2
  } l2_state_t;

  typedef struct packed {
    l2_state_t                 state;
    logic [L2_TAG_BITS-1:0]    tag;
    logic [CACHELINE_BITS-1:0] data;
  } l2_cacheline_t;

  typedef enum logic [2:0] {
    CTRL_IDLE      = 3'd0,
    CTRL_LOOKUP    = 3'd1,
    CTRL_WB_REQ    = 3'd2,
    CTRL_FILL_REQ  = 3'd3,
    CTRL_FILL_WAIT = 3'd4,
    CTRL_RESP      = 3'd5
  } ctrl_state_t;

  function automatic l2_cacheline_t make_line(input l2_state_t s,
                                              input logic [L2_TAG_BITS-1:0] t,
                                              input logic [CACHELINE_BITS-1:0] d);
    l2_cacheline_t l;
    l.state = s;
    l.tag   = t;
    l.data  = d;
    return l;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/l2_cache_ctrl_tag_data_array.sv
// Tag/state/data storage for the 16 L2 sets: combinational read, one write
// port, and asynchronous invalidate of every line on reset.
module l2_tag_data_array
  import l2_cache_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [L2_INDEX_BITS-1:0] rd_index,
  output l2_cacheline_t            rd_line,
  input  logic                     we,
  input  logic [L2_INDEX_BITS-1:0] wr_index,
  input  l2_cacheline_t            wr_line
);

  l2_cacheline_t lines [L2_SETS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < L2_SETS; i++) lines[i] <= '0;
    end else if (we) begin
      lines[wr_index] <= wr_line;
    end
  end

  assign rd_line = lines[rd_index];

endmodule

// File: rtl/l2_cache_ctrl.sv
// Direct-mapped write-back L2 controller: one request at a time, misses and
// dirty evictions go through a single-outstanding memory port.
// Statistics counters exist only when L2_STATS_EN is defined.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a valid that is raised stays high with stable payload until
// that edge (l2_req_* from the bus, mem_req_* towards memory).
module l2_cache_ctrl
  import l2_cache_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      l2_req_valid,
  output logic                      l2_req_ready,
  input  logic [L2_ADDR_W-1:0]      l2_req_addr,
  input  logic                      l2_req_rw,
  input  logic [CACHELINE_BITS-1:0] l2_req_data,
  output logic                      l2_resp_valid,
  output logic [CACHELINE_BITS-1:0] l2_resp_data,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [L2_ADDR_W-1:0]      mem_req_addr,
  output logic                      mem_req_rw,
  output logic [CACHELINE_BITS-1:0] mem_req_data,
  input  logic                      mem_resp_valid,
  input  logic [CACHELINE_BITS-1:0] mem_resp_data,
  output logic [15:0]               hit_cnt,
  output logic [15:0]               miss_cnt,
  output logic [15:0]               wb_cnt
);

  ctrl_state_t                state, next_state;
  logic [L2_ADDR_W-1:0]       req_addr;
  logic                       req_rw;
  logic [CACHELINE_BITS-1:0]  req_data;
  logic [CACHELINE_BITS-1:0]  resp_q;
  l2_cacheline_t              line;
  l2_cacheline_t              wr_line;
  logic                       arr_we;
  logic                       lookup_hit;
  logic [L2_TAG_BITS-1:0]     req_tag;
  logic [L2_INDEX_BITS-1:0]   req_index;

  assign req_tag    = req_addr[L2_ADDR_W-1:L2_INDEX_BITS];
  assign req_index  = req_addr[L2_INDEX_BITS-1:0];
  assign lookup_hit = (line.state != L2_I) && (line.tag == req_tag);

  l2_tag_data_array u_array (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_index (req_index),
    .rd_line  (line),
    .we       (arr_we),
    .wr_index (req_index),
    .wr_line  (wr_line)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= CTRL_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    arr_we     = 1'b0;
    wr_line    = '0;
    case (state)
      CTRL_IDLE: if (l2_req_valid) next_state = CTRL_LOOKUP;
      CTRL_LOOKUP: begin
        if (lookup_hit) begin
          if (!req_rw) begin
            next_state = CTRL_RESP;
          end else begin
            arr_we     = 1'b1;
            wr_line    = make_line(L2_D, req_tag, req_data);
            next_state = CTRL_IDLE;
          end
        end else if (line.state == L2_D) begin
          next_state = CTRL_WB_REQ;
        end else if (!req_rw) begin
          next_state = CTRL_FILL_REQ;
        end else begin
          // Write-back miss over a clean victim: whole line supplied, no fill.
          arr_we     = 1'b1;
          wr_line    = make_line(L2_D, req_tag, req_data);
          next_state = CTRL_IDLE;
        end
      end
      CTRL_WB_REQ: begin
        if (mem_req_ready) begin
          if (req_rw) begin
            arr_we     = 1'b1;
            wr_line    = make_line(L2_D, req_tag, req_data);
            next_state = CTRL_IDLE;
          end else begin
            next_state = CTRL_FILL_REQ;
          end
        end
      end
      CTRL_FILL_REQ: if (mem_req_ready) next_state = CTRL_FILL_WAIT;
      CTRL_FILL_WAIT: begin
        if (mem_resp_valid) begin
          arr_we     = 1'b1;
          wr_line    = make_line(L2_C, req_tag, mem_resp_data);
          next_state = CTRL_RESP;
        end
      end
      CTRL_RESP: next_state = CTRL_IDLE;
      default:   next_state = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_addr <= '0;
      req_rw   <= 1'b0;
      req_data <= '0;
      resp_q   <= '0;
    end else begin
      if (state == CTRL_IDLE && l2_req_valid) begin
        req_addr <= l2_req_addr;
        req_rw   <= l2_req_rw;
        req_data <= l2_req_data;
      end
      if (state == CTRL_LOOKUP && lookup_hit && !req_rw) resp_q <= line.data;
      if (state == CTRL_FILL_WAIT && mem_resp_valid)      resp_q <= mem_resp_data;
    end
  end

  // The victim line is untouched until the eviction completes, so reading it
  // straight from the array keeps the eviction payload stable while stalled.
  assign l2_req_ready  = (state == CTRL_IDLE);
  assign l2_resp_valid = (state == CTRL_RESP);
  assign l2_resp_data  = (state == CTRL_RESP) ? resp_q : '0;
  assign mem_req_valid = (state == CTRL_WB_REQ) || (state == CTRL_FILL_REQ);
  assign mem_req_rw    = (state == CTRL_WB_REQ);
  assign mem_req_addr  = (state == CTRL_WB_REQ)   ? {line.tag, req_index} :
                         (state == CTRL_FILL_REQ) ? req_addr : '0;
  assign mem_req_data  = (state == CTRL_WB_REQ) ? line.data : '0;

`ifdef L2_STATS_EN
  logic [15:0] hit_q, miss_q, wb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q  <= '0;
      miss_q <= '0;
      wb_q   <= '0;
    end else begin
      if (state == CTRL_LOOKUP) begin
        if (lookup_hit) hit_q  <= sat_inc(hit_q);
        else            miss_q <= sat_inc(miss_q);
      end
      if (state == CTRL_WB_REQ && mem_req_ready) wb_q <= sat_inc(wb_q);
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
  assign wb_cnt   = wb_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
  assign wb_cnt   = '0;
`endif

endmodule
